// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply/divide unit with one start/done handshake and held HI/LO.
// Define MULDIV_ABORT_EN to add an abort input that cancels a running operation.
module muldiv_iter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N    = WIDTH / UNROLL;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mq_q, mq_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;

  logic [WIDTH:0]    t;
  logic [WIDTH-1:0]  ta, tm;
  logic [2*WIDTH-1:0] prod;
  logic              sa, sb;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    sa       = ~op[0] & a[WIDTH-1];
    sb       = ~op[0] & b[WIDTH-1];

    // acc holds the high product / partial remainder, mq the low product / quotient.
    t  = '0;
    ta = acc_q;
    tm = mq_q;
    for (int i = 0; i < int'(UNROLL); i++) begin
      if (is_div_q) begin
        t  = {ta, tm[WIDTH-1]};
        tm = {tm[WIDTH-2:0], 1'b0};
        if (t >= {1'b0, opb_q}) begin
          t     = t - {1'b0, opb_q};
          tm[0] = 1'b1;
        end
        ta = t[WIDTH-1:0];
      end else begin
        t  = tm[0] ? ({1'b0, ta} + {1'b0, opb_q}) : {1'b0, ta};
        tm = {t[0], tm[WIDTH-1:1]};
        ta = t[WIDTH:1];
      end
    end

    prod = {acc_q, mq_q};
    if (neg_lo_q) prod = -prod;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op[1] && (b == '0)) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            state_d  = StRun;
            cnt_d    = '0;
            is_div_d = op[1];
            neg_lo_d = sa ^ sb;
            neg_hi_d = sa;
            acc_d    = '0;
            mq_d     = sa ? -a : a;
            opb_d    = sb ? -b : b;
          end
        end
      end
      StRun: begin
        acc_d = ta;
        mq_d  = tm;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = neg_lo_q ? -mq_q : mq_q;
          hi_d = neg_hi_q ? -acc_q : acc_q;
        end else begin
          lo_d = prod[WIDTH-1:0];
          hi_d = prod[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef MULDIV_ABORT_EN
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: a 32/1 instance and a 32/4 instance driven by separate starts.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset, start1, start4, abort4;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy1, done1, dz1, busy4, done4, dz4;
  logic [31:0] hi1, lo1, hi4, lo4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32), .UNROLL(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b),
`ifdef MULDIV_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy1), .done(done1), .div_zero(dz1), .hi(hi1), .lo(lo1)
  );

  muldiv_iter #(.WIDTH(32), .UNROLL(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .op(op), .a(a), .b(b),
`ifdef MULDIV_ABORT_EN
    .abort(abort4),
`endif
    .busy(busy4), .done(done4), .div_zero(dz4), .hi(hi4), .lo(lo4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge 1 is the start-sampling edge; lat is the edge number on which done is seen.
  task automatic run_op(input bit u4, input logic [1:0] o, input logic [31:0] xa,
                        input logic [31:0] xb, output int lat, output bit saw_busy);
    op = o;
    a  = xa;
    b  = xb;
    if (u4) start4 = 1'b1;
    else    start1 = 1'b1;
    tick();
    start1   = 1'b0;
    start4   = 1'b0;
    lat      = 1;
    saw_busy = 1'b0;
    while (!(u4 ? done4 : done1) && lat < 100) begin
      saw_busy = saw_busy | (u4 ? busy4 : busy1);
      tick();
      lat++;
    end
  endtask

  initial begin
    int  lat, ndone, done_edge;
    bit  sb;
    logic [31:0] hcap, lcap;

    reset = 1'b1; start1 = 1'b0; start4 = 1'b0; abort4 = 1'b0;
    op = 2'b00; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    check_eq("rst_busy", {63'd0, busy1}, 64'd0);
    check_eq("rst_done", {63'd0, done1}, 64'd0);
    check_eq("rst_dz",   {63'd0, dz1},   64'd0);
    check_eq("rst_hi",   {32'd0, hi1},   64'd0);
    check_eq("rst_lo",   {32'd0, lo1},   64'd0);
    check_eq("rst_busy4", {63'd0, busy4}, 64'd0);

    // MULT -3 * 7
    run_op(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd7, lat, sb);
    check_eq("mult_lat",  lat, 34);
    check_eq("mult_hi",   {32'd0, hi1}, 64'hFFFF_FFFF);
    check_eq("mult_lo",   {32'd0, lo1}, 64'hFFFF_FFEB);
    check_eq("mult_busy", {63'd0, busy1}, 64'd0);
    check_eq("mult_dz",   {63'd0, dz1}, 64'd0);
    tick();
    check_eq("done_pulse", {63'd0, done1}, 64'd0);

    // DIVU 100 / 7, then DIV -7 / 2 started in the done cycle of the first
    run_op(1'b0, 2'b11, 32'd100, 32'd7, lat, sb);
    check_eq("divu_lo", {32'd0, lo1}, 64'd14);
    check_eq("divu_hi", {32'd0, hi1}, 64'd2);
    run_op(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, lat, sb);
    check_eq("div_b2b_lat", lat, 34);
    check_eq("div_lo", {32'd0, lo1}, 64'hFFFF_FFFD);
    check_eq("div_hi", {32'd0, hi1}, 64'hFFFF_FFFF);

    // Divide by zero: immediate done, no busy, hi/lo held
    run_op(1'b0, 2'b10, 32'd5, 32'd0, lat, sb);
    check_eq("dz_lat",  lat, 1);
    check_eq("dz_flag", {63'd0, dz1}, 64'd1);
    check_eq("dz_busy", {63'd0, sb | busy1}, 64'd0);
    check_eq("dz_hi",   {32'd0, hi1}, 64'hFFFF_FFFF);
    check_eq("dz_lo",   {32'd0, lo1}, 64'hFFFF_FFFD);
    tick();
    check_eq("dz_clear", {63'd0, dz1}, 64'd0);

    // Overflow case and unsigned max square
    run_op(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, sb);
    check_eq("ovf_lo", {32'd0, lo1}, 64'h8000_0000);
    check_eq("ovf_hi", {32'd0, hi1}, 64'd0);
    check_eq("ovf_dz", {63'd0, dz1}, 64'd0);
    run_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, sb);
    check_eq("multu_hi", {32'd0, hi1}, 64'hFFFF_FFFE);
    check_eq("multu_lo", {32'd0, lo1}, 64'h0000_0001);

    // Extra sign combinations
    run_op(1'b0, 2'b10, 32'd7, 32'hFFFF_FFFE, lat, sb);
    check_eq("div_nb_lo", {32'd0, lo1}, 64'hFFFF_FFFD);
    check_eq("div_nb_hi", {32'd0, hi1}, 64'd1);
    run_op(1'b0, 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, lat, sb);
    check_eq("mult_nn", {hi1, lo1}, 64'd6);

    // Start pulses and operand changes while busy are ignored
    op = 2'b00; a = 32'd3; b = 32'd5; start1 = 1'b1;
    tick();
    start1 = 1'b0; ndone = 0; done_edge = 0; hcap = '1; lcap = '1;
    for (int e = 2; e <= 40; e++) begin
      if (e == 5) begin
        op = 2'b11; a = 32'd9; b = 32'd9;
      end
      start1 = (e == 5) || (e == 20);
      tick();
      start1 = 1'b0;
      if (done1) begin
        ndone++;
        done_edge = e;
        hcap = hi1;
        lcap = lo1;
      end
    end
    check_eq("ign_ndone", ndone, 1);
    check_eq("ign_edge",  done_edge, 34);
    check_eq("ign_res",   {hcap, lcap}, 64'd15);

    // Reset mid-operation
    op = 2'b00; a = 32'd3; b = 32'd5; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int e = 2; e <= 10; e++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rmid_busy", {63'd0, busy1}, 64'd0);
    check_eq("rmid_hilo", {hi1, lo1}, 64'd0);
    ndone = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (done1) ndone++;
    end
    check_eq("rmid_nodone", ndone, 0);

    // UNROLL=4 instance
    run_op(1'b1, 2'b00, 32'd1234, 32'd5678, lat, sb);
    check_eq("u4_lat", lat, 10);
    check_eq("u4_lo",  {32'd0, lo4}, 64'd7006652);
    check_eq("u4_hi",  {32'd0, hi4}, 64'd0);
    run_op(1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, lat, sb);
    check_eq("u4_div", {hi4, lo4}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(1'b1, 2'b00, 32'd1234, 32'd5678, lat, sb);

`ifdef MULDIV_ABORT_EN
    op = 2'b00; a = 32'd2; b = 32'd3; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    check_eq("ab_busy", {63'd0, busy4}, 64'd0);
    check_eq("ab_done", {63'd0, done4}, 64'd0);
    ndone = 0;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (done4) ndone++;
    end
    check_eq("ab_nodone", ndone, 0);
    check_eq("ab_hilo", {hi4, lo4}, 64'd7006652);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
